// File: rtl/mul16_seq_if.sv
// Operand/result bundle between mul16_seq and its requester.
// The ovf signal exists only when MUL16_OVF_EN is defined.
interface mul16_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
`ifdef MUL16_OVF_EN
  logic        ovf;

  modport master (
    output start, a, b,
    input  busy, done, product, ovf
  );
  modport slave (
    input  start, a, b,
    output busy, done, product, ovf
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, product
  );
  modport slave (
    input  start, a, b,
    output busy, done, product
  );
`endif
endinterface

// File: rtl/mul16_seq.sv
// 16x16 unsigned shift-and-add multiplier around one cla16 adder.
// Define MUL16_OVF_EN to add the registered ovf (product > 16 bits) flag.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;

  assign g = a & b;
  assign p = a ^ b;

  // Four 4-bit lookahead groups chained by group generate/propagate.
  always_comb begin
    c = '0;
    gg = '0;
    gp = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[4*i+1] = g[4*i] | (p[4*i] & c[4*i]);
      c[4*i+2] = g[4*i+1]
               | (p[4*i+1] & g[4*i])
               | (p[4*i+1] & p[4*i] & c[4*i]);
      c[4*i+3] = g[4*i+2]
               | (p[4*i+2] & g[4*i+1])
               | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
      c[4*i+4] = gg[i] | (gp[i] & c[4*i]);
    end
  end

  assign s    = p ^ c[15:0];
  assign cout = c[16];
endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        rst,
  mul16_seq_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] mcand;
  logic [15:0] acc;
  logic [15:0] mq;
  logic [4:0]  cnt;
  logic [31:0] product;
  logic        done_q;
  logic [15:0] add_b;
  logic [15:0] sum;
  logic        cout;
  logic        last;

  assign add_b = mq[0] ? mcand : 16'h0000;
  assign last  = (state == RUN) && (cnt == 5'd15);

  cla16 u_add (
    .a    (acc),
    .b    (add_b),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      cnt     <= '0;
      product <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand <= bus.a;
            mq    <= bus.b;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= {cout, sum[15:1]};
          mq  <= {sum[0], mq[15:1]};
          cnt <= cnt + 5'd1;
          if (last) begin
            product <= {cout, sum[15:1], sum[0], mq[15:1]};
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL16_OVF_EN
  logic ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf <= 1'b0;
    else if (last)
      ovf <= |{cout, sum[15:1]};
  end

  assign bus.ovf = ovf;
`endif

  assign bus.busy    = (state == RUN);
  assign bus.done    = done_q;
  assign bus.product = product;
endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq: results, latency, busy window, reset.
// Build with MUL16_OVF_EN defined to also check the ovf flag.
module tb_mul16_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   run_start = -1;

  typedef struct {
    logic [31:0] prod;
    int          acc;
  } exp_t;

  exp_t q[$];

  mul16_seq_if bus();

  mul16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Busy window and completions, sampled mid-cycle.
  always @(negedge clk) begin
    logic eb;
    eb = (run_start >= 0) && (cyc >= run_start)
      && (cyc <= run_start + 15);
    chk("busy", {31'b0, bus.busy}, {31'b0, eb});
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("product", bus.product, e.prod);
        chk("latency", cyc - e.acc, 32'd16);
`ifdef MUL16_OVF_EN
        chk("ovf", {31'b0, bus.ovf}, {31'b0, |e.prod[31:16]});
`endif
      end
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    @(negedge clk);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    e.prod = 32'(x) * 32'(y);
    e.acc = cyc + 1;
    q.push_back(e);
    run_start = cyc + 1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, bus.done}, 32'd0);
    chk({tag, "_prod"}, bus.product, 32'd0);
`ifdef MUL16_OVF_EN
    chk({tag, "_ovf"}, {31'b0, bus.ovf}, 32'd0);
`endif
  endtask

  initial begin
    int acc1;
    exp_t e;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(16'd3, 16'd5);
    drain();
    issue(16'hFFFF, 16'hFFFF);
    drain();
    issue(16'h0000, 16'h1234);
    drain();
    issue(16'h1234, 16'h0001);
    drain();

    // start while busy must be ignored; product holds old value
    issue(16'd7, 16'd9);
    repeat (4) @(negedge clk);
    chk("hold_in_run", bus.product, 32'h0000_1234);
    bus.a = 16'd2;
    bus.b = 16'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.a = 16'hDEAD;
    bus.b = 16'hBEEF;
    drain();

    // back-to-back: start held through the DONE cycle
    @(negedge clk);
    bus.a = 16'h0100;
    bus.b = 16'h0100;
    bus.start = 1'b1;
    acc1 = cyc + 1;
    e.prod = 32'h0001_0000;
    e.acc = acc1;
    q.push_back(e);
    run_start = acc1;
    while (cyc < acc1 + 16) @(negedge clk);
    e.acc = cyc + 1;
    q.push_back(e);
    run_start = cyc + 1;
    chk("b2b_gap", e.acc + 16 - (acc1 + 16), 32'd17);
    @(posedge clk);
    #1 bus.start = 1'b0;
    drain();

    // mid-run reset discards the operation
    issue(16'hABCD, 16'h1234);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    q.delete();
    run_start = -1;
    #1 chk_zero("midrst");
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(16'd6, 16'd7);
    drain();

    for (int i = 0; i < 4; i++) begin
      issue(16'($urandom), 16'($urandom));
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mul16_seq.md
# mul16_seq

Sequential 16x16 unsigned shift-and-add multiplier built around one instance of the existing 16-bit carry look-ahead adder `cla16`. It registers two operands on a start strobe and drives the adder's A/B/Cin inputs once per cycle. It consumes the adder's S/Cout outputs to build a 32-bit product over 16 iterations. It sits directly around the adder: it is the control and datapath stage that feeds `cla16` and absorbs its result.

## Interface
- No parameters; widths fixed at 16-bit operands and a 32-bit product.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  16  multiplicand; captured on the accepting edge.
- `b`  in  16  multiplier; captured on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; product valid.
- `product`  out  32  last completed result; held until the next completion.
- `ovf`  out  1  present only with `MUL16_OVF_EN`; see Configuration.

## Operation
- Internal registers:
  - `mcand[15:0]`
  - `acc[15:0]`, the running high half
  - `mq[15:0]`, the multiplier being shifted out as product low bits accumulate
  - `cnt[4:0]`
  - `state` ∈ {IDLE, RUN, DONE}
- Adder hookup: A = `acc`, B = `mq[0] ? mcand : 16'h0`, Cin = 0. Sum S and Cout are combinational from `cla16`.
- IDLE:
  - `start`=1 → load `mcand`=`a`, `mq`=`b`, `acc`=0, `cnt`=0, go to RUN.
  - Otherwise remain in IDLE.
- RUN, on each edge:
  - `acc` ← {Cout, S[15:1]}
  - `mq` ← {S[0], mq[15:1]}
  - `cnt` ← `cnt`+1
  - The 16th step (`cnt`==15) transfers to DONE. On that same edge `product` ← {Cout, S[15:1], S[0], mq[15:1]}, which is the post-step {acc, mq}.
- DONE, lasting one cycle:
  - `done`=1.
  - `start`=1 → load as in IDLE and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- `start` in RUN is ignored with no side effects. Operands `a`/`b` may change freely after acceptance.
- Arithmetic: the product is exact unsigned, `a*b` mod 2^32. Overflow cannot occur, because the {Cout, S} 17-bit sum always fits the shifted 32-bit register.
- Reset (any time, including mid-RUN):
  - `state`=IDLE; `acc`, `mq`, `mcand`, `cnt` = 0.
  - Outputs: `busy`=0, `done`=0, `product`=0, `ovf`=0.
  - An in-flight operation is discarded with no `done` pulse.

## Timing
- Accepting edge E0: `busy` rises after E0.
- Edges E1..E16 perform the 16 add/shift steps.
- After E16: `busy`=0, `done`=1, and `product` is updated. `done` therefore first appears in the cycle following E16, i.e. 16 cycles after `busy` rises.
- `done` and `product` are registered; `busy` is decoded from `state`. No combinational path runs from inputs to outputs.
- Throughput: one multiply per 17 cycles with back-to-back `start` in DONE. With `start` first sampled in IDLE after DONE, it is one per 18 cycles.
- `product` is stable during RUN; it shows the previous result.

## Configuration
- `MUL16_OVF_EN` defined:
  - Adds output `ovf`, registered and updated on the same edge as `product`.
  - `ovf` = 1 iff the new product[31:16] ≠ 0, i.e. the result does not fit in 16 bits.
  - `ovf` holds with `product` and resets to 0.
- `MUL16_OVF_EN` undefined:
  - The `ovf` port and its register are absent.
  - All other behaviour is identical.

## Test plan
- Basic multiply: `a`=3, `b`=5, `start` pulse → `busy` high 16 cycles, then `done`=1 for one cycle with `product`=32'h0000000F and `ovf`=0.
- Maximum operands: `a`=16'hFFFF, `b`=16'hFFFF → `product`=32'hFFFE0001, `ovf`=1 (when enabled); checks Cout propagation.
- Zero and pass-through: `a`=0, `b`=16'h1234 gives `product`=0. Then `a`=16'h1234, `b`=1 gives `product`=32'h00001234 with `ovf`=0.
- Start while busy: `a`=7, `b`=9 accepted; re-assert `start` with `a`=2, `b`=2 at cycle 5 of RUN → ignored, result 32'h0000003F at the original `done` time.
- Back-to-back: `start` held high with `a`=16'h0100, `b`=16'h0100 → first `done` shows `product`=32'h00010000 (`ovf`=1). The next operation starts in the DONE cycle, and the second `done` arrives exactly 17 cycles after the first.
- Mid-run reset: assert `rst` for one cycle at cycle 8 of RUN → outputs go to 0 immediately (asynchronously), no `done` pulse, next `start` with `a`=6, `b`=7 yields `product`=42.
